// File: rtl/rc4_ctrl_pkg.sv
// Shared state encoding, S-RAM ownership and RAM geometry for the RC4 key-search controller.
// state_owner() maps each controller state to the engine that drives the shared S-RAM port.
package rc4_ctrl_pkg;

  localparam int RC4_RAM_WIDTH  = 8;
  localparam int RC4_RAM_LENGTH = 8;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_L_INIT    = 4'd1;
  localparam state_t ST_W_INIT    = 4'd2;
  localparam state_t ST_L_KSA     = 4'd3;
  localparam state_t ST_W_KSA     = 4'd4;
  localparam state_t ST_L_DEC     = 4'd5;
  localparam state_t ST_W_DEC     = 4'd6;
  localparam state_t ST_NEXT      = 4'd7;
  localparam state_t ST_FOUND     = 4'd8;
  localparam state_t ST_EXHAUSTED = 4'd9;
  localparam state_t ST_ERR       = 4'd10;

  typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_KSA, OWN_DEC} owner_t;

  // NEXT stays with the decryptor so its last access is not cut off mid-cycle.
  function automatic owner_t state_owner(input state_t st);
    case (st)
      ST_L_INIT, ST_W_INIT:         return OWN_INIT;
      ST_L_KSA, ST_W_KSA:           return OWN_KSA;
      ST_L_DEC, ST_W_DEC, ST_NEXT:  return OWN_DEC;
      default:                      return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_s_ram_mux.sv
// Selects one engine's S-RAM request onto the shared port; combinational, zero latency.
// With no owner the port is parked at address 0, data 0, no write.
module s_ram_mux
  import rc4_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH  = RC4_RAM_WIDTH,
  parameter int RAM_LENGTH = RC4_RAM_LENGTH
) (
  input  owner_t                owner,
  input  logic [RAM_LENGTH-1:0] init_addr,
  input  logic [RAM_WIDTH-1:0]  init_data,
  input  logic                  init_wren,
  input  logic [RAM_LENGTH-1:0] ksa_addr,
  input  logic [RAM_WIDTH-1:0]  ksa_data,
  input  logic                  ksa_wren,
  input  logic [RAM_LENGTH-1:0] dec_addr,
  input  logic [RAM_WIDTH-1:0]  dec_data,
  input  logic                  dec_wren,
  output logic [RAM_LENGTH-1:0] s_addr,
  output logic [RAM_WIDTH-1:0]  s_data,
  output logic                  s_wren
);

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wren = 1'b0;
    case (owner)
      OWN_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      OWN_KSA: begin
        s_addr = ksa_addr;
        s_data = ksa_data;
        s_wren = ksa_wren;
      end
      OWN_DEC: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Walks KEY_MIN..KEY_MAX running S-init, KSA and decrypt per key; stops on success, exhaustion or watchdog.
// Engine launch pulses trail the launch state by one cycle; S-RAM muxing is combinational.
module rc4_key_search_ctrl
  import rc4_ctrl_pkg::*;
#(
  parameter int                  KEY_BITS       = 24,
  parameter logic [KEY_BITS-1:0] KEY_MIN        = '0,
  parameter logic [KEY_BITS-1:0] KEY_MAX        = 24'h3FFFFF,
  parameter int                  TIMEOUT_CYCLES = 4096,
  parameter int                  RAM_WIDTH      = RC4_RAM_WIDTH,
  parameter int                  RAM_LENGTH     = RC4_RAM_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [KEY_BITS-1:0]   key,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  error,
  output logic                  init_start,
  output logic                  ksa_start,
  output logic                  dec_start,
  input  logic                  init_done,
  input  logic                  ksa_done,
  input  logic                  dec_finished,
  input  logic                  dec_success,
  input  logic [RAM_LENGTH-1:0] init_addr,
  input  logic [RAM_WIDTH-1:0]  init_data,
  input  logic                  init_wren,
  input  logic [RAM_LENGTH-1:0] ksa_addr,
  input  logic [RAM_WIDTH-1:0]  ksa_data,
  input  logic                  ksa_wren,
  input  logic [RAM_LENGTH-1:0] dec_addr,
  input  logic [RAM_WIDTH-1:0]  dec_data,
  input  logic                  dec_wren,
  output logic [RAM_LENGTH-1:0] s_addr,
  output logic [RAM_WIDTH-1:0]  s_data,
  output logic                  s_wren
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  // The wait ends on the edge where the count would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic             in_wait;
  logic             wdog_trip;
  owner_t           owner;

  assign in_wait   = (state == ST_W_INIT) || (state == ST_W_KSA) || (state == ST_W_DEC);
  assign wdog_trip = (phase_cnt == CNT_TRIP);
  assign busy      = (state != ST_IDLE);
  assign owner     = state_owner(state);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_L_INIT;
      ST_L_INIT: state_nxt = ST_W_INIT;
      ST_W_INIT: begin
        if (init_done)      state_nxt = ST_L_KSA;
        else if (wdog_trip) state_nxt = ST_ERR;
      end
      ST_L_KSA:  state_nxt = ST_W_KSA;
      ST_W_KSA: begin
        if (ksa_done)       state_nxt = ST_L_DEC;
        else if (wdog_trip) state_nxt = ST_ERR;
      end
      ST_L_DEC:  state_nxt = ST_W_DEC;
      ST_W_DEC: begin
        if (dec_finished) begin
          if (dec_success)         state_nxt = ST_FOUND;
          else if (key == KEY_MAX) state_nxt = ST_EXHAUSTED;
          else                     state_nxt = ST_NEXT;
        end else if (wdog_trip) begin
          state_nxt = ST_ERR;
        end
      end
      ST_NEXT:   state_nxt = ST_L_INIT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      key        <= KEY_MIN;
      done       <= 1'b0;
      found      <= 1'b0;
      error      <= 1'b0;
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      dec_start  <= 1'b0;
      phase_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      init_start <= (state == ST_L_INIT);
      ksa_start  <= (state == ST_L_KSA);
      dec_start  <= (state == ST_L_DEC);
      phase_cnt  <= in_wait ? phase_cnt + CNT_W'(1) : '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            key   <= KEY_MIN;
            done  <= 1'b0;
            found <= 1'b0;
            error <= 1'b0;
          end
        end
        ST_NEXT:      key <= key + KEY_BITS'(1);
        ST_FOUND: begin
          found <= 1'b1;
          done  <= 1'b1;
        end
        ST_EXHAUSTED: begin
          found <= 1'b0;
          done  <= 1'b1;
        end
        ST_ERR: begin
          error <= 1'b1;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  s_ram_mux #(
    .RAM_WIDTH  (RAM_WIDTH),
    .RAM_LENGTH (RAM_LENGTH)
  ) u_s_ram_mux (
    .owner     (owner),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_wren (init_wren),
    .ksa_addr  (ksa_addr),
    .ksa_data  (ksa_data),
    .ksa_wren  (ksa_wren),
    .dec_addr  (dec_addr),
    .dec_data  (dec_data),
    .dec_wren  (dec_wren),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .s_wren    (s_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: behavioural engines, a phase-level reference model checked every cycle,
// a table of whole-search scenarios, hand-written reset/held-start sequences and randomized runs.
module tb_rc4_key_search_ctrl;
  import rc4_ctrl_pkg::*;

  localparam int             KB   = 24;
  localparam int             TO   = 16;
  localparam logic [KB-1:0]  KMIN = 24'd0;
  localparam logic [KB-1:0]  KMAX = 24'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KB-1:0] key;
  logic          busy, done, found, error;
  logic          init_start, ksa_start, dec_start;
  logic          init_done = 1'b0, ksa_done = 1'b0, dec_finished = 1'b0, dec_success = 1'b0;
  logic [7:0]    init_addr = 8'd0, init_data = 8'd0, ksa_addr = 8'd0, ksa_data = 8'd0;
  logic [7:0]    dec_addr = 8'd0, dec_data = 8'd0;
  logic          init_wren = 1'b0, ksa_wren = 1'b0, dec_wren = 1'b0;
  logic [7:0]    s_addr, s_data;
  logic          s_wren;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // engine configuration (written by the main sequence only)
  int lat_init = 5, lat_ksa = 5, lat_dec = 5;
  int succ_key = -1;
  bit withhold = 1'b0;
  bit noise = 1'b0;
  int stray_cycle = -1;
  // engine observations (written by the engine process only)
  int n_init = 0;
  int ksa_cyc = 0;

  rc4_key_search_ctrl #(
    .KEY_BITS(KB), .KEY_MIN(KMIN), .KEY_MAX(KMAX), .TIMEOUT_CYCLES(TO),
    .RAM_WIDTH(8), .RAM_LENGTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done), .found(found), .error(error),
    .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
    .init_done(init_done), .ksa_done(ksa_done),
    .dec_finished(dec_finished), .dec_success(dec_success),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engines: done a fixed latency after each launch, random S-RAM traffic every cycle.
  initial begin
    int init_cd, ksa_cd, dec_cd;
    logic [KB-1:0] dec_key;
    init_cd = 0; ksa_cd = 0; dec_cd = 0; dec_key = '0;
    forever begin
      @(negedge clk);
      init_done = 1'b0; ksa_done = 1'b0; dec_finished = 1'b0;
      dec_success = noise ? 1'($urandom) : 1'b0;
      if (init_cd > 0) begin init_cd--; if (init_cd == 0) init_done = 1'b1; end
      if (ksa_cd > 0)  begin ksa_cd--;  if (ksa_cd == 0)  ksa_done = 1'b1; end
      if (dec_cd > 0) begin
        dec_cd--;
        if (dec_cd == 0) begin
          dec_finished = 1'b1;
          dec_success  = (succ_key >= 0) && (dec_key == KB'(succ_key));
        end
      end
      if (cyc == stray_cycle) init_done = 1'b1;
      if (noise) begin
        if ($urandom_range(0, 31) == 0) init_done = 1'b1;
        if ($urandom_range(0, 31) == 0) ksa_done = 1'b1;
        if ($urandom_range(0, 31) == 0) dec_finished = 1'b1;
      end
      if (init_start) begin init_cd = lat_init; n_init++; end
      if (ksa_start)  begin ksa_cd = withhold ? 0 : lat_ksa; ksa_cyc = cyc; end
      if (dec_start)  begin dec_cd = lat_dec; dec_key = key; end
      {init_addr, init_data, init_wren} = 17'($urandom);
      {ksa_addr, ksa_data, ksa_wren}    = 17'($urandom);
      {dec_addr, dec_data, dec_wren}    = 17'($urandom);
    end
  end

  // Reference model: phase 0 idle, 1 init, 2 ksa, 3 decrypt, 4 advance key, 5 report result.
  int            m_ph = 0;
  bit            m_launch = 1'b0;
  int            m_wcnt = 0;
  int            m_kind = 0;
  logic [KB-1:0] m_key = KMIN;
  bit            m_done = 1'b0, m_found = 1'b0, m_error = 1'b0;
  bit [2:0]      m_pulse = 3'b000;

  initial begin
    bit fin;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_ph = 0; m_launch = 1'b0; m_wcnt = 0; m_key = KMIN;
        m_done = 1'b0; m_found = 1'b0; m_error = 1'b0; m_pulse = 3'b000;
      end else begin
        m_pulse = 3'b000;
        if (m_ph >= 1 && m_ph <= 3 && m_launch) m_pulse[m_ph-1] = 1'b1;
        case (m_ph)
          0: if (start) begin
            m_ph = 1; m_launch = 1'b1; m_key = KMIN;
            m_done = 1'b0; m_found = 1'b0; m_error = 1'b0;
          end
          1, 2, 3: begin
            if (m_launch) begin
              m_launch = 1'b0; m_wcnt = 0;
            end else begin
              fin = (m_ph == 1) ? init_done : (m_ph == 2) ? ksa_done : dec_finished;
              if (fin) begin
                if (m_ph < 3)             begin m_ph++; m_launch = 1'b1; end
                else if (dec_success)     begin m_ph = 5; m_kind = 1; end
                else if (m_key == KMAX)   begin m_ph = 5; m_kind = 2; end
                else                      m_ph = 4;
              end else begin
                m_wcnt++;
                if (m_wcnt >= TO - 1) begin m_ph = 5; m_kind = 3; end
              end
            end
          end
          4: begin m_key = m_key + 1; m_ph = 1; m_launch = 1'b1; end
          default: begin
            m_done = 1'b1; m_found = (m_kind == 1); m_error = (m_kind == 3); m_ph = 0;
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic cycle_check();
    logic [7:0] ea, ed;
    logic       ew;
    ea = 8'd0; ed = 8'd0; ew = 1'b0;
    if (m_ph == 1)                    begin ea = init_addr; ed = init_data; ew = init_wren; end
    else if (m_ph == 2)               begin ea = ksa_addr;  ed = ksa_data;  ew = ksa_wren;  end
    else if (m_ph == 3 || m_ph == 4)  begin ea = dec_addr;  ed = dec_data;  ew = dec_wren;  end
    check("cycle", {busy, done, found, error, init_start, ksa_start, dec_start, key, s_addr, s_data, s_wren},
          {m_ph != 0, m_done, m_found, m_error, m_pulse[0], m_pulse[1], m_pulse[2], m_key, ea, ed, ew});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (chk_en) cycle_check();
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    repeat (len) tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int end_cyc);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin tick(); n++; end
    check(name, {63'd0, busy}, 64'd0);
    end_cyc = cyc;
  endtask

  task automatic wait_pulse(input string name, input int which, input int budget);
    int n = 0;
    logic [2:0] p;
    p = {dec_start, ksa_start, init_start};
    while (p[which] !== 1'b1 && n < budget) begin
      tick(); n++;
      p = {dec_start, ksa_start, init_start};
    end
    check(name, {63'd0, p[which]}, 64'd1);
  endtask

  typedef struct {
    int            succ;
    bit            hold_ksa;
    bit            e_found;
    bit            e_error;
    logic [KB-1:0] e_key;
    int            e_inits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t_end, n0, s;
    vecs[0] = '{2,  1'b0, 1'b1, 1'b0, 24'd2, 3};
    vecs[1] = '{-1, 1'b0, 1'b0, 1'b0, 24'd3, 4};
    vecs[2] = '{0,  1'b0, 1'b1, 1'b0, 24'd0, 1};
    vecs[3] = '{3,  1'b0, 1'b1, 1'b0, 24'd3, 4};
    vecs[4] = '{1,  1'b1, 1'b0, 1'b1, 24'd0, 1};

    reset = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    check("reset_state", {busy, done, found, error, init_start, ksa_start, dec_start, key, s_addr, s_data, s_wren},
          {7'b0, KMIN, 17'b0});
    tick();
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 5; i++) begin
      succ_key = vecs[i].succ; withhold = vecs[i].hold_ksa;
      lat_init = 5; lat_ksa = 5; lat_dec = 5;
      n0 = n_init;
      pulse_start(1);
      wait_idle("vec_run", 400, t_end);
      check("vec_flags", {done, found, error, busy}, {1'b1, vecs[i].e_found, vecs[i].e_error, 1'b0});
      check("vec_key", key, vecs[i].e_key);
      check("vec_inits", n_init - n0, vecs[i].e_inits);
      if (vecs[i].hold_ksa) begin
        check("timeout_latency", t_end - ksa_cyc, 16);
        check("idle_s_wren", {s_addr, s_data, s_wren}, 17'd0);
      end
      repeat (20) tick();
    end
    withhold = 1'b0;

    // Reset while waiting on the decryptor for key 1; its finish pulse lands after the reset.
    succ_key = -1;
    pulse_start(1);
    wait_pulse("rst_dec1", 2, 200);
    tick();
    wait_pulse("rst_dec2", 2, 200);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_outs", {busy, done, found, error, init_start, ksa_start, dec_start, s_wren}, 8'd0);
    check("rst_mid_key", key, KMIN);
    repeat (10) tick();
    check("rst_after_fin", {busy, done, found, error, key}, {4'b0, KMIN});
    succ_key = 1;
    n0 = n_init;
    pulse_start(1);
    wait_idle("rst_rerun", 400, t_end);
    check("rst_rerun_res", {done, found, error, key}, {3'b110, 24'd1});
    check("rst_rerun_inits", n_init - n0, 2);
    repeat (10) tick();

    // start held high across a whole search, with a stray init_done while waiting on the KSA.
    succ_key = 1;
    n0 = n_init;
    start = 1'b1;
    tick();
    wait_idle("held_run1", 400, t_end);
    check("held_first_done", {done, found, busy}, 3'b110);
    check("held_first_inits", n_init - n0, 2);
    tick();
    check("held_restart", {busy, done}, 2'b10);
    wait_pulse("held_ksa", 1, 100);
    stray_cycle = cyc + 2;
    start = 1'b0;
    wait_idle("held_run2", 400, t_end);
    stray_cycle = -1;
    check("held_second_res", {done, found, error, key}, {3'b110, 24'd1});
    check("held_total_inits", n_init - n0, 4);
    repeat (10) tick();

    // Randomized searches with stray pulses, garbage success, varied latencies and occasional resets.
    noise = 1'b1;
    for (int r = 0; r < 40; r++) begin
      s = $urandom_range(0, 4);
      succ_key = (s == 4) ? -1 : s;
      lat_init = $urandom_range(1, 16);
      lat_ksa  = $urandom_range(1, 16);
      lat_dec  = $urandom_range(1, 16);
      withhold = ($urandom_range(0, 7) == 0);
      pulse_start($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 40)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      wait_idle("rnd_run", 600, t_end);
      repeat ($urandom_range(2, 20)) tick();
    end
    noise = 1'b0;
    withhold = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
